// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcodes, ALU-control and mux-select encodings shared by the control path.
package mc_ctrl_pkg;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_RI  = 2'b01;
    localparam logic [1:0] ALU_BR  = 2'b10;

    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;
    localparam logic       SRCB_RS2  = 1'b0;
    localparam logic       SRCB_IMM  = 1'b1;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    typedef enum logic [3:0] {
        C_OP, C_OPIMM, C_LOAD, C_STORE, C_LUI, C_AUIPC, C_BRANCH, C_JAL, C_JALR, C_ILL
    } op_class_t;
endpackage

// File: rtl/mc_ctrl_op_class_dec.sv
// op_class_dec: opcode to instruction class plus legal flag.
import mc_ctrl_pkg::*;

module op_class_dec (
    input  logic [6:0] opcode,
    output op_class_t  cls,
    output logic       legal
);
    always_comb begin
        case (opcode)
            OPC_OP:     cls = C_OP;
            OPC_OP_IMM: cls = C_OPIMM;
            OPC_LOAD:   cls = C_LOAD;
            OPC_STORE:  cls = C_STORE;
            OPC_LUI:    cls = C_LUI;
            OPC_AUIPC:  cls = C_AUIPC;
            OPC_BRANCH: cls = C_BRANCH;
            OPC_JAL:    cls = C_JAL;
            OPC_JALR:   cls = C_JALR;
            default:    cls = C_ILL;
        endcase
        legal = cls != C_ILL;
    end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main control FSM; state and halted are the only flops,
// all strobes and selects decode combinationally from state, opcode and br_taken.
import mc_ctrl_pkg::*;

module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       br_taken,
    input  logic       imem_rdy,
    input  logic       dmem_rdy,
    output logic       imem_re,
    output logic       ir_we,
    output logic       dmem_re,
    output logic       dmem_we,
    output logic [1:0] alu_src_a,
    output logic       alu_src_b,
    output logic [1:0] aluCtrlOp,
    output logic       itype,
    output logic       alu_out_we,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       retire,
    output logic       halted
);
    typedef enum logic [3:0] {
        S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    state_t    state;
    op_class_t cls;
    logic      legal;

    op_class_dec u_dec (.opcode(opcode), .cls(cls), .legal(legal));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_BOOT;
            halted <= 1'b0;
        end else begin
            case (state)
                S_BOOT:   state <= S_FETCH;
                S_FETCH:  if (imem_rdy) state <= S_DECODE;
                S_DECODE: begin
                    if (!legal) halted <= 1'b1;
                    state <= !legal ? S_HALT :
                             cls == C_BRANCH ? S_BRANCH :
                             (cls == C_JAL || cls == C_JALR) ? S_JUMP : S_EXEC;
                end
                S_EXEC:   state <= (cls == C_LOAD || cls == C_STORE) ? S_MEM : S_WB;
                S_MEM:    if (dmem_rdy) state <= cls == C_LOAD ? S_WB : S_FETCH;
                S_WB, S_BRANCH, S_JUMP: state <= S_FETCH;
                S_HALT:   state <= S_HALT;
                default:  state <= S_BOOT;
            endcase
        end
    end

    always_comb begin
        imem_re    = 1'b0;
        ir_we      = 1'b0;
        dmem_re    = 1'b0;
        dmem_we    = 1'b0;
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        aluCtrlOp  = ALU_ADD;
        itype      = 1'b0;
        alu_out_we = 1'b0;
        reg_we     = 1'b0;
        wb_sel     = WB_ALU;
        pc_we      = 1'b0;
        pc_sel     = PC_PLUS4;
        retire     = 1'b0;
        case (state)
            S_FETCH: begin
                imem_re = 1'b1;
                ir_we   = imem_rdy;
            end
            S_EXEC: begin
                alu_out_we = 1'b1;
                alu_src_a  = cls == C_LUI ? SRCA_ZERO : cls == C_AUIPC ? SRCA_PC : SRCA_RS1;
                alu_src_b  = cls == C_OP ? SRCB_RS2 : SRCB_IMM;
                aluCtrlOp  = (cls == C_OP || cls == C_OPIMM) ? ALU_RI : ALU_ADD;
                itype      = cls == C_OPIMM;
            end
            S_MEM: begin
                dmem_re = cls == C_LOAD;
                dmem_we = cls == C_STORE;
                pc_we   = cls == C_STORE && dmem_rdy;
                retire  = cls == C_STORE && dmem_rdy;
            end
            S_WB: begin
                reg_we = 1'b1;
                wb_sel = cls == C_LOAD ? WB_LOAD : WB_ALU;
                pc_we  = 1'b1;
                retire = 1'b1;
            end
            S_BRANCH: begin
                aluCtrlOp = ALU_BR;
                pc_we     = 1'b1;
                pc_sel    = br_taken ? PC_IMM : PC_PLUS4;
                retire    = 1'b1;
            end
            S_JUMP: begin
                alu_src_b = cls == C_JALR ? SRCB_IMM : SRCB_RS2;
                reg_we    = 1'b1;
                wb_sel    = WB_PC4;
                pc_we     = 1'b1;
                pc_sel    = cls == C_JALR ? PC_ALU : PC_IMM;
                retire    = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven per-cycle output checks plus halt and reset corner sequences.
module tb_mc_ctrl;
    typedef struct packed {
        logic       imem_re, ir_we, dmem_re, dmem_we;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [1:0] aluop;
        logic       itype, alu_out_we, reg_we;
        logic [1:0] wb_sel;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       retire, halted;
    } outs_t;

    typedef struct {
        logic [6:0] opc;
        logic       br, ir, dr;
        outs_t      exp;
    } vec_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       br_taken = 1'b0, imem_rdy = 1'b0, dmem_rdy = 1'b0;
    logic       imem_re, ir_we, dmem_re, dmem_we, alu_src_b, itype, alu_out_we;
    logic       reg_we, pc_we, retire, halted;
    logic [1:0] alu_src_a, aluCtrlOp, wb_sel, pc_sel;
    outs_t      got;
    int         errors = 0, checks = 0, nret = 0;
    vec_t       tv[$];

    mc_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken),
        .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy), .imem_re(imem_re), .ir_we(ir_we),
        .dmem_re(dmem_re), .dmem_we(dmem_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .aluCtrlOp(aluCtrlOp), .itype(itype), .alu_out_we(alu_out_we), .reg_we(reg_we),
        .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    assign got = {imem_re, ir_we, dmem_re, dmem_we, alu_src_a, alu_src_b, aluCtrlOp, itype,
                  alu_out_we, reg_we, wb_sel, pc_we, pc_sel, retire, halted};

    function automatic outs_t o(input int ire, irw, dre, dwe, sa, sb, aop, it, aw, rw, wb, pw, ps, ret, h);
        outs_t r;
        r.imem_re = 1'(ire); r.ir_we = 1'(irw); r.dmem_re = 1'(dre); r.dmem_we = 1'(dwe);
        r.alu_src_a = 2'(sa); r.alu_src_b = 1'(sb); r.aluop = 2'(aop); r.itype = 1'(it);
        r.alu_out_we = 1'(aw); r.reg_we = 1'(rw); r.wb_sel = 2'(wb); r.pc_we = 1'(pw);
        r.pc_sel = 2'(ps); r.retire = 1'(ret); r.halted = 1'(h);
        return r;
    endfunction

    function automatic void add(input logic [6:0] opc, input logic br, ir, dr, input outs_t e);
        tv.push_back('{opc, br, ir, dr, e});
    endfunction

    task automatic chk(input string nm, input outs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%05h expected=%05h", nm, got, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int g, input int e);
        checks++;
        if (g != e) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", nm, g, e);
        end
    endtask

    task automatic step(input logic [6:0] opc, input logic ir, dr);
        @(negedge clk);
        opcode = opc; imem_rdy = ir; dmem_rdy = dr;
        #1;
    endtask

    localparam logic [6:0] ADD = 7'b0110011, ADDI = 7'b0010011, LUI = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111, SW = 7'b0100011, LW = 7'b0000011;
    localparam logic [6:0] BEQ = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;

    initial begin
        outs_t z, fet, fwait, wbr, exm, memld;
        z     = o(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0);
        fet   = o(1,1,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0);
        fwait = o(1,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0);
        wbr   = o(0,0,0,0, 0,0,0,0, 0,1,0, 1,0,1, 0);
        exm   = o(0,0,0,0, 0,1,0,0, 1,0,0, 0,0,0, 0);
        memld = o(0,0,1,0, 0,0,0,0, 0,0,0, 0,0,0, 0);

        add(ADD, 0, 1, 0, fet); add(ADD, 0, 1, 1, z);
        add(ADD, 0, 1, 1, o(0,0,0,0, 0,0,1,0, 1,0,0, 0,0,0, 0)); add(ADD, 0, 1, 0, wbr);
        add(ADDI, 0, 1, 0, fet); add(ADDI, 0, 1, 0, z);
        add(ADDI, 0, 1, 0, o(0,0,0,0, 0,1,1,1, 1,0,0, 0,0,0, 0)); add(ADDI, 0, 1, 0, wbr);
        add(LUI, 0, 1, 0, fet); add(LUI, 0, 1, 0, z);
        add(LUI, 0, 1, 0, o(0,0,0,0, 2,1,0,0, 1,0,0, 0,0,0, 0)); add(LUI, 0, 1, 0, wbr);
        add(AUIPC, 1, 1, 0, fet); add(AUIPC, 1, 1, 0, z);
        add(AUIPC, 1, 1, 0, o(0,0,0,0, 1,1,0,0, 1,0,0, 0,0,0, 0)); add(AUIPC, 1, 1, 0, wbr);
        add(SW, 0, 0, 1, fwait); add(SW, 0, 1, 1, fet); add(SW, 0, 0, 1, z);
        add(SW, 0, 0, 1, exm);
        add(SW, 0, 0, 1, o(0,0,0,1, 0,0,0,0, 0,0,0, 1,0,1, 0));
        add(LW, 0, 1, 0, fet); add(LW, 0, 1, 0, z); add(LW, 0, 1, 1, exm);
        add(LW, 0, 1, 0, memld); add(LW, 0, 1, 0, memld); add(LW, 0, 1, 0, memld);
        add(LW, 0, 0, 1, memld);
        add(LW, 0, 0, 0, o(0,0,0,0, 0,0,0,0, 0,1,1, 1,0,1, 0));
        add(BEQ, 1, 1, 0, fet); add(BEQ, 1, 1, 0, z);
        add(BEQ, 1, 1, 0, o(0,0,0,0, 0,0,2,0, 0,0,0, 1,1,1, 0));
        add(BEQ, 0, 1, 0, fet); add(BEQ, 0, 1, 0, z);
        add(BEQ, 0, 1, 0, o(0,0,0,0, 0,0,2,0, 0,0,0, 1,0,1, 0));
        add(JAL, 0, 1, 0, fet); add(JAL, 0, 1, 0, z);
        add(JAL, 0, 1, 0, o(0,0,0,0, 0,0,0,0, 0,1,2, 1,1,1, 0));
        add(JALR, 0, 1, 0, fet); add(JALR, 0, 1, 0, z);
        add(JALR, 0, 1, 0, o(0,0,0,0, 0,1,0,0, 0,1,2, 1,2,1, 0));

        #1 chk("reset", z);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("boot", z);

        foreach (tv[i]) begin
            @(negedge clk);
            opcode = tv[i].opc; br_taken = tv[i].br; imem_rdy = tv[i].ir; dmem_rdy = tv[i].dr;
            #1 chk($sformatf("vec%0d_op%07b", i, tv[i].opc), tv[i].exp);
            if (retire) nret++;
        end
        chk_int("retire_count", nret, 10);

        step(7'b1111111, 1, 1); chk("ill_fetch", fet);
        step(7'b1111111, 1, 1); chk("ill_decode", z);
        for (int k = 0; k < 20; k++) begin
            step(7'b1111111, 1, 1);
            chk($sformatf("halt%0d", k), o(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 1));
        end
        @(negedge clk);
        rst = 1'b1;
        #1 chk("halt_rst", z);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("halt_boot", z);
        step(LW, 1, 0); chk("resume_fetch", fet);

        nret = 0;
        step(LW, 1, 0); chk("ld_decode", z);
        step(LW, 1, 0); chk("ld_exec", exm);
        step(LW, 1, 0); chk("ld_mem_wait", memld);
        #2 rst = 1'b1;
        #1 chk("mem_rst", z);
        if (retire) nret++;
        @(negedge clk);
        rst = 1'b0; dmem_rdy = 1'b1;
        #1 chk("mem_rst_boot", z);
        if (retire) nret++;
        step(LW, 1, 1); chk("mem_rst_fetch", fet);
        chk_int("mem_rst_retires", nret, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main control FSM for the mini CPU core. Steps each instruction through fetch, decode, execute, memory and write-back. Produces all datapath strobes and mux selects, including the 2-bit `aluCtrlOp`/`itype` pair consumed by the ALU control decoder. Sits beside the IR/PC/register-file datapath and stalls on instruction- and data-memory ready handshakes.

## Interface
- No parameters; XLEN-independent.
- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 7: IR[6:0], valid from DECODE onward.
- `br_taken` in 1: ALU compare result bit 0, valid in BRANCH.
- `imem_rdy` in 1: instruction memory data valid.
- `dmem_rdy` in 1: data memory access complete.
- `imem_re` out 1: instruction read request.
- `ir_we` out 1: IR load.
- `dmem_re`, `dmem_we` out 1 each: data read / write request.
- `alu_src_a` out 2: 00 rs1, 01 PC, 10 zero.
- `alu_src_b` out 1: 0 rs2, 1 imm.
- `aluCtrlOp` out 2: 00 add (address/LUI/AUIPC/JALR), 01 R/I ALU, 10 branch compare.
- `itype` out 1: high for OP-IMM in EXEC.
- `alu_out_we` out 1: latch ALU result into alu_out.
- `reg_we` out 1: register-file write.
- `wb_sel` out 2: 00 alu_out, 01 load data, 10 PC+4.
- `pc_we` out 1: PC load.
- `pc_sel` out 2: 00 PC+4, 01 PC+imm, 10 ALU result with bit 0 cleared.
- `retire` out 1: one-cycle pulse, instruction complete.
- `halted` out 1: sticky illegal-opcode flag.

## Operation
- States: BOOT, FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP, HALT.
- Reset: state forced to BOOT asynchronously. In BOOT all outputs are 0. BOOT→FETCH unconditionally.
- FETCH: `imem_re`=1 held until `imem_rdy`. On `imem_rdy`: `ir_we`=1, go to DECODE.
- DECODE: no strobes. Next state by opcode:
  - OP, OP-IMM, LOAD, STORE, LUI, AUIPC → EXEC
  - BRANCH → BRANCH
  - JAL, JALR → JUMP
  - any other opcode → HALT
- EXEC: `alu_out_we`=1 in all cases. Selects by opcode:
  - OP: src_a=rs1, src_b=rs2, aluCtrlOp=01.
  - OP-IMM: src_a=rs1, src_b=imm, aluCtrlOp=01, `itype`=1.
  - LOAD/STORE: src_a=rs1, src_b=imm, aluCtrlOp=00.
  - LUI: src_a=zero, src_b=imm, aluCtrlOp=00.
  - AUIPC: src_a=PC, src_b=imm, aluCtrlOp=00.
  - Next state: MEM for LOAD/STORE, else WB.
- MEM: `dmem_re` (LOAD) or `dmem_we` (STORE) held until `dmem_rdy`.
  - LOAD then goes to WB.
  - STORE completes in MEM on `dmem_rdy`: `pc_we`=1, pc_sel=00, `retire`=1, → FETCH.
- WB: `reg_we`=1; wb_sel=01 for LOAD, else 00. Also `pc_we`=1, pc_sel=00, `retire`=1, → FETCH.
- BRANCH: src_a=rs1, src_b=rs2, aluCtrlOp=10. `pc_we`=1, pc_sel = `br_taken` ? 01 : 00. `retire`=1, → FETCH.
- JUMP: `reg_we`=1, wb_sel=10, `pc_we`=1, `retire`=1, → FETCH.
  - JAL: pc_sel=01.
  - JALR: src_a=rs1, src_b=imm, aluCtrlOp=00, pc_sel=10.
- HALT: all strobes 0, `halted`=1. Exits only via `rst`.
- Invariants:
  - Exactly one `pc_we` and one `retire` per instruction, in the same cycle.
  - `imem_re`, `dmem_re` and `dmem_we` are mutually exclusive.
  - Unlisted outputs are 0 in every state.

## Timing
- State register and `halted` are the only flops. All other outputs decode combinationally from state, opcode and `br_taken`.
- Minimum cycles per instruction, zero-wait memory:
  - BRANCH, JAL, JALR: 3.
  - OP, OP-IMM, LUI, AUIPC, STORE: 4.
  - LOAD: 5.
- Each wait cycle on `imem_rdy` or `dmem_rdy` adds one cycle. Request outputs stay asserted and unchanged while waiting.
- `rst` asserted mid-instruction: state goes to BOOT immediately, outputs drop to 0, and no partial `reg_we`/`pc_we` is issued. First FETCH is 2 cycles after `rst` deasserts.
- Ready inputs are ignored outside their waiting state.

## Structure
- Shared defines header holds:
  - Opcode constants.
  - aluCtrlOp encodings (00/01/10), consumed by the ALU control decoder.
  - Mux-select encodings for alu_src_a/b, wb_sel and pc_sel.
- State encoding is local to `mc_ctrl`.
- Sub-module `op_class_dec`: combinational opcode → instruction class plus legal flag, reused by the disassembler/trace monitor.

## Test plan
- ADD (0110011), imem_rdy tied high → imem_re, ir_we in cycle 1. alu_out_we with aluCtrlOp=01, itype=0 in cycle 3. reg_we, wb_sel=00, pc_we, pc_sel=00, retire in cycle 4.
- ADDI (0010011) → EXEC drives itype=1, alu_src_b=1, aluCtrlOp=01.
- LW with dmem_rdy delayed 3 cycles → dmem_re held 4 cycles. Then WB with wb_sel=01. Total 8 cycles, single retire.
- BEQ, once with br_taken=1 and once with 0 → 3 cycles, aluCtrlOp=10. pc_sel=01 for taken, 00 for not taken. reg_we never asserted.
- JALR → cycle 3 asserts reg_we, wb_sel=10, pc_sel=10, aluCtrlOp=00, alu_src_a=00.
- Opcode 1111111 → HALT after DECODE, halted=1, all strobes 0 for 20 cycles. rst pulse clears halted and BOOT→FETCH resumes. Separately, rst asserted during MEM wait → dmem_re drops the same cycle with no retire.
